// File: rtl/vector_add_issue.sv
// vector_add_issue: issue/drain controller for the external 16-lane FP32 vector adder.
//   Joins operand streams A (with tag) and B, issues one pair per cycle to the adder,
//   captures returning sums into a result FIFO paired in order with a tag FIFO, and
//   presents {m_data, m_tag} on a valid/ready stream. A credit counter bounds pairs
//   issued but not yet popped to DEPTH, since the adder cannot be stalled.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   s_a_data/s_a_tag/s_a_valid/s_a_ready   operand A stream and tag
//   s_b_data/s_b_valid/s_b_ready           operand B stream
//   add_vector_1/2, add_input_valid        registered adder inputs
//   add_output_valid, add_vector           adder result
//   m_data/m_tag/m_valid/m_ready           result stream
//   busy                         work outstanding or post-reset flush active
//   err_unexpected               sticky: result arrived with nothing outstanding
module vector_add_issue #(
    parameter int DATA_W  = 512,
    parameter int TAG_W   = 16,
    parameter int DEPTH   = 8,
    parameter int ADD_LAT = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_a_data,
    input  logic [TAG_W-1:0]  s_a_tag,
    input  logic              s_a_valid,
    output logic              s_a_ready,
    input  logic [DATA_W-1:0] s_b_data,
    input  logic              s_b_valid,
    output logic              s_b_ready,
    output logic [DATA_W-1:0] add_vector_1,
    output logic [DATA_W-1:0] add_vector_2,
    output logic              add_input_valid,
    input  logic              add_output_valid,
    input  logic [DATA_W-1:0] add_vector,
    output logic [DATA_W-1:0] m_data,
    output logic [TAG_W-1:0]  m_tag,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              err_unexpected
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = $clog2(ADD_LAT + 2);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [FW-1:0] F_INIT = FW'(ADD_LAT + 1);
    localparam logic [FW-1:0] F_ONE = FW'(1);

    logic [FW-1:0]     r_flush;
    logic [CW-1:0]     r_credit;
    logic [CW-1:0]     r_inflight;
    logic [AW:0]       r_res_wp, r_res_rp, r_tag_wp, r_tag_rp;
    logic [DATA_W-1:0] r_res_mem [DEPTH];
    logic [TAG_W-1:0]  r_tag_mem [DEPTH];
    logic              r_add_vld;
    logic [DATA_W-1:0] r_v1, r_v2;
    logic              r_err;

    logic w_flush, w_can_issue, w_fire, w_pop, w_res_vld, w_res_wr;

    // Results arriving during the flush window belong to pairs issued before reset.
    assign w_flush     = r_flush != '0;
    assign w_can_issue = (r_credit != '0) & ~w_flush;
    assign w_fire      = s_a_valid & s_b_valid & w_can_issue;
    assign w_pop       = m_valid & m_ready;
    assign w_res_vld   = add_output_valid & ~w_flush;
    assign w_res_wr    = w_res_vld & (r_inflight != '0);

    assign s_a_ready       = s_b_valid & w_can_issue;
    assign s_b_ready       = s_a_valid & w_can_issue;
    assign add_vector_1    = r_v1;
    assign add_vector_2    = r_v2;
    assign add_input_valid = r_add_vld;
    assign m_valid         = r_res_wp != r_res_rp;
    // Gate the unreset FIFO storage so outputs read as zero while empty.
    assign m_data          = m_valid ? r_res_mem[r_res_rp[AW-1:0]] : '0;
    assign m_tag           = m_valid ? r_tag_mem[r_tag_rp[AW-1:0]] : '0;
    assign busy            = (r_credit != C_FULL) | w_flush;
    assign err_unexpected  = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush    <= F_INIT;
            r_credit   <= C_FULL;
            r_inflight <= '0;
            r_res_wp   <= '0;
            r_res_rp   <= '0;
            r_tag_wp   <= '0;
            r_tag_rp   <= '0;
            r_add_vld  <= 1'b0;
            r_v1       <= '0;
            r_v2       <= '0;
            r_err      <= 1'b0;
        end else begin
            r_flush    <= w_flush ? r_flush - F_ONE : r_flush;
            r_credit   <= (w_fire & ~w_pop) ? r_credit - C_ONE :
                          (w_pop & ~w_fire) ? r_credit + C_ONE : r_credit;
            r_inflight <= (w_fire & ~w_res_wr) ? r_inflight + C_ONE :
                          (w_res_wr & ~w_fire) ? r_inflight - C_ONE : r_inflight;
            r_res_wp   <= r_res_wp + (AW+1)'(w_res_wr);
            r_res_rp   <= r_res_rp + (AW+1)'(w_pop);
            r_tag_wp   <= r_tag_wp + (AW+1)'(w_fire);
            r_tag_rp   <= r_tag_rp + (AW+1)'(w_pop);
            r_add_vld  <= w_fire;
            r_v1       <= w_fire ? s_a_data : r_v1;
            r_v2       <= w_fire ? s_b_data : r_v2;
            r_err      <= r_err | (w_res_vld & (r_inflight == '0));
        end
    end

    always_ff @(posedge clk) begin
        if (w_res_wr) r_res_mem[r_res_wp[AW-1:0]] <= add_vector;
        if (w_fire) r_tag_mem[r_tag_wp[AW-1:0]] <= s_a_tag;
    end
endmodule

// File: tb/tb_vector_add_issue.sv
// tb_vector_add_issue: directed bench for vector_add_issue with an integer-valued FP32 adder model.
module tb_vector_add_issue;
    localparam int DW = 512;
    localparam int TW = 16;
    localparam int DEPTH = 8;
    localparam int ADD_LAT = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [DW-1:0] s_a_data, s_b_data, add_vector_1, add_vector_2, add_vector, m_data;
    logic [TW-1:0] s_a_tag, m_tag;
    logic s_a_valid, s_a_ready, s_b_valid, s_b_ready, add_input_valid, add_output_valid;
    logic m_valid, m_ready, busy, err_unexpected;
    logic inj = 1'b0;
    logic [ADD_LAT-1:0] pv = '0;
    logic [DW-1:0] pd [ADD_LAT];
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] tag;
        logic [31:0] sum;
    } vec_t;
    vec_t tbl [5];

    vector_add_issue #(.DATA_W(DW), .TAG_W(TW), .DEPTH(DEPTH), .ADD_LAT(ADD_LAT)) dut (
        .clk(clk), .rst(rst),
        .s_a_data(s_a_data), .s_a_tag(s_a_tag), .s_a_valid(s_a_valid), .s_a_ready(s_a_ready),
        .s_b_data(s_b_data), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
        .add_vector_1(add_vector_1), .add_vector_2(add_vector_2), .add_input_valid(add_input_valid),
        .add_output_valid(add_output_valid), .add_vector(add_vector),
        .m_data(m_data), .m_tag(m_tag), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .err_unexpected(err_unexpected)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] i2f(int n);
        int p;
        p = 0;
        if (n == 0) return 32'h0;
        for (int i = 0; i < 24; i++) if (n[i]) p = i;
        return {1'b0, 8'(127 + p), 23'((n << (23 - p)) & 32'h7FFFFF)};
    endfunction

    function automatic int f2i(logic [31:0] f);
        int e;
        int m;
        if (f[30:0] == 31'h0) return 0;
        e = int'(f[30:23]) - 127;
        m = int'({1'b1, f[22:0]});
        return m >> (23 - e);
    endfunction

    function automatic logic [DW-1:0] mkvec(int b, int s);
        logic [DW-1:0] v;
        for (int l = 0; l < 16; l++) v[32*l +: 32] = i2f(b + s * l);
        return v;
    endfunction

    function automatic logic [DW-1:0] addv(logic [DW-1:0] a, logic [DW-1:0] b);
        logic [DW-1:0] v;
        for (int l = 0; l < 16; l++) v[32*l +: 32] = i2f(f2i(a[32*l +: 32]) + f2i(b[32*l +: 32]));
        return v;
    endfunction

    // Adder model: fixed latency, no reset, no backpressure.
    always @(posedge clk) begin
        pv <= {pv[ADD_LAT-2:0], add_input_valid};
        pd[0] <= addv(add_vector_1, add_vector_2);
        for (int i = 1; i < ADD_LAT; i++) pd[i] <= pd[i-1];
    end
    assign add_output_valid = pv[ADD_LAT-1] | inj;
    assign add_vector = pd[ADD_LAT-1];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic present(input int tag, input logic [DW-1:0] a, input logic [DW-1:0] b);
        s_a_tag = tag[TW-1:0];
        s_a_data = a;
        s_b_data = b;
        s_a_valid = 1'b1;
        s_b_valid = 1'b1;
    endtask

    task automatic idle();
        s_a_valid = 1'b0;
        s_b_valid = 1'b0;
    endtask

    task automatic wait_mvalid(input string nm);
        int c;
        c = 0;
        while (!m_valid && c < 60) begin
            cyc();
            c++;
        end
        chk(nm, 64'(m_valid), 64'd1);
    endtask

    task automatic pop_one();
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, fired, next_tag, exp_tag, beats, cnt, zero;
        logic f, seen;
        s_a_data = '0; s_b_data = '0; s_a_tag = '0;
        idle();
        m_ready = 1'b0;
        tbl[0] = '{32'h3F800000, 32'h40000000, 16'h0005, 32'h40400000};
        tbl[1] = '{32'h40400000, 32'h40800000, 16'h1234, 32'h40E00000};
        tbl[2] = '{32'h00000000, 32'h41200000, 16'hFFFF, 32'h41200000};
        tbl[3] = '{32'h41200000, 32'h41200000, 16'h0000, 32'h41A00000};
        tbl[4] = '{32'h42C80000, 32'h3F800000, 16'hABCD, 32'h42CA0000};

        repeat (3) @(posedge clk);
        #1;
        chk("reset m_valid", 64'(m_valid), 0);
        chk("reset add_input_valid", 64'(add_input_valid), 0);
        chk("reset err", 64'(err_unexpected), 0);
        chk("reset add_vector_1", 64'(|add_vector_1), 0);
        chk("reset busy(flush)", 64'(busy), 1);
        rst = 1'b0;
        repeat (ADD_LAT + 2) cyc();
        chk("idle busy", 64'(busy), 0);

        for (int i = 0; i < 5; i++) begin
            present(int'(tbl[i].tag), {16{tbl[i].a}}, {16{tbl[i].b}});
            #1;
            chk("tbl fire", 64'(s_a_ready & s_b_ready), 1);
            cyc();
            idle();
            chk("tbl add_input_valid pulse", 64'(add_input_valid), 1);
            chk_vec("tbl add_vector_1", add_vector_1, {16{tbl[i].a}});
            cyc();
            chk("tbl add_input_valid one-shot", 64'(add_input_valid), 0);
            lat = 2;
            while (!m_valid && lat < 40) begin
                cyc();
                lat++;
            end
            chk("tbl latency", 64'(lat), 64'(ADD_LAT + 2));
            chk_vec("tbl sum", m_data, {16{tbl[i].sum}});
            chk("tbl tag", 64'(m_tag), 64'(tbl[i].tag));
            cyc();
            chk("tbl tag hold", 64'(m_tag), 64'(tbl[i].tag));
            pop_one();
            chk("tbl empty after pop", 64'(m_valid), 0);
        end

        fired = 0;
        for (int c = 0; c < 12; c++) begin
            present(fired, mkvec(fired, 1), mkvec(0, 1));
            #1;
            f = s_a_ready & s_b_ready;
            cyc();
            if (f) fired++;
        end
        #1;
        chk("credit fires", 64'(fired), 8);
        chk("ready at credit 0", 64'(s_a_ready), 0);
        chk("busy at credit 0", 64'(busy), 1);
        wait_mvalid("credit first result");
        chk("credit head tag", 64'(m_tag), 0);
        chk_vec("credit head data", m_data, mkvec(0, 2));
        m_ready = 1'b1;
        #1;
        chk("no fire in pop cycle", 64'(s_a_ready), 0);
        cyc();
        m_ready = 1'b0;
        #1;
        chk("fire after pop", 64'(s_a_ready & s_b_ready), 1);
        cyc();
        idle();
        wait_mvalid("credit second result");
        chk("credit tag 1", 64'(m_tag), 1);
        pop_one();

        present(9, mkvec(9, 1), mkvec(0, 1));
        m_ready = 1'b1;
        #1;
        chk("fire at credit 1", 64'(s_a_ready & s_b_ready), 1);
        chk("pop with fire", 64'(m_valid), 1);
        chk("pop with fire tag", 64'(m_tag), 2);
        cyc();
        m_ready = 1'b0;
        present(10, mkvec(10, 1), mkvec(0, 1));
        #1;
        chk("credit held at 1", 64'(s_a_ready & s_b_ready), 1);
        cyc();
        present(11, mkvec(11, 1), mkvec(0, 1));
        #1;
        chk("credit 0 after fire", 64'(s_a_ready), 0);
        next_tag = 11;
        exp_tag = 3;

        m_ready = 1'b1;
        beats = 0;
        cnt = 0;
        while (beats < 20 && cnt < 300) begin
            present(next_tag, mkvec(next_tag, 1), mkvec(0, 1));
            #1;
            f = s_a_ready & s_b_ready;
            if (m_valid) begin
                chk("stream tag order", 64'(m_tag), 64'(exp_tag));
                chk_vec("stream data", m_data, mkvec(exp_tag, 2));
                exp_tag++;
                beats++;
            end
            cyc();
            if (f) next_tag++;
            cnt++;
        end
        chk("stream beats", 64'(beats), 20);
        idle();
        cnt = 0;
        while (busy && cnt < 100) begin
            if (m_valid) begin
                chk("drain tag order", 64'(m_tag), 64'(exp_tag));
                exp_tag++;
            end
            cyc();
            cnt++;
        end
        m_ready = 1'b0;
        chk("drained busy", 64'(busy), 0);
        chk("drain count", 64'(exp_tag), 64'(next_tag));

        s_a_tag = 16'h0044;
        s_a_data = mkvec(5, 0);
        s_b_data = mkvec(6, 0);
        s_a_valid = 1'b1;
        s_b_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("lone a ready", 64'(s_a_ready), 0);
            chk("lone a no issue", 64'(add_input_valid), 0);
            cyc();
        end
        s_b_valid = 1'b1;
        #1;
        chk("join fire", 64'(s_a_ready & s_b_ready), 1);
        cyc();
        idle();
        chk("join issue", 64'(add_input_valid), 1);
        wait_mvalid("join result");
        chk("join tag", 64'(m_tag), 64'h44);
        chk_vec("join data", m_data, mkvec(11, 0));
        pop_one();

        for (int k = 0; k < 3; k++) begin
            present(16'h50 + k, mkvec(k, 1), mkvec(1, 1));
            #1;
            chk("pre-reset fire", 64'(s_a_ready & s_b_ready), 1);
            cyc();
        end
        idle();
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("async reset busy", 64'(busy), 1);
        cyc();
        rst = 1'b0;
        present(16'h60, mkvec(2, 2), mkvec(3, 0));
        zero = 0;
        seen = 1'b0;
        cnt = 0;
        while (cnt < 30) begin
            #1;
            if (s_a_ready & s_b_ready) break;
            zero++;
            seen = seen | m_valid;
            cyc();
            cnt++;
        end
        chk("flush ready-low cycles", 64'(zero), 64'(ADD_LAT + 1));
        chk("flush m_valid", 64'(seen), 0);
        chk("flush err", 64'(err_unexpected), 0);
        cyc();
        idle();
        wait_mvalid("post-flush result");
        chk("post-flush tag", 64'(m_tag), 64'h60);
        chk_vec("post-flush data", m_data, mkvec(5, 2));
        chk("post-flush err", 64'(err_unexpected), 0);
        pop_one();

        repeat (3) cyc();
        inj = 1'b1;
        cyc();
        inj = 1'b0;
        chk("unexpected err set", 64'(err_unexpected), 1);
        chk("unexpected m_valid", 64'(m_valid), 0);
        chk("unexpected busy", 64'(busy), 0);
        repeat (3) cyc();
        chk("unexpected err sticky", 64'(err_unexpected), 1);
        chk("unexpected m_valid later", 64'(m_valid), 0);
        rst = 1'b1;
        #1;
        chk("err cleared by rst", 64'(err_unexpected), 0);
        cyc();
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
